// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters, with a one-deep
// valid/ready response register. Define ALU_ARB_STATS_EN to add per-requester grant counters.

package alu_pipelined_pkg;
    parameter int unsigned WIDTH = 32;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSltu = 4'd6;
    localparam logic [3:0] AluSll  = 4'd7;
    localparam logic [3:0] AluSrl  = 4'd8;
    localparam logic [3:0] AluSra  = 4'd9;
endpackage

module alu_rr_arbiter
    import alu_pipelined_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NREQ-1:0]               req_valid_i,
    output logic [NREQ-1:0]               req_ready_o,
    input  logic [NREQ*WIDTH-1:0]         req_a_i,
    input  logic [NREQ*WIDTH-1:0]         req_b_i,
    input  logic [NREQ*4-1:0]             req_ctrl_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [$clog2(NREQ)-1:0]       rsp_id_o,
    output logic [WIDTH-1:0]              rsp_result_o,
    output logic [3:0]                    rsp_flags_o
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic                          stats_clr_i,
    output logic [NREQ*16-1:0]            gnt_cnt_o
`endif
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned ShW = $clog2(WIDTH);

    logic [IDW-1:0]   ptr_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [3:0]       rsp_flags_q;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic             slot_free;
    logic             xfer;

    logic [WIDTH-1:0] op_a, op_b, alu_res;
    logic [3:0]       op_ctrl, alu_flags;
    logic [WIDTH:0]   alu_sum;
    logic             alu_c, alu_of;

    // Lowest valid index overall, then overridden by the lowest valid index at or above ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(k);
            end
        end
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (req_valid_i[k] && (IDW'(k) >= ptr_q)) begin
                gnt_idx = IDW'(k);
            end
        end
    end

    assign slot_free   = !rsp_valid_q || rsp_ready_i;
    assign xfer        = gnt_found && slot_free && !rst_i;
    assign req_ready_o = xfer ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        op_a    = '0;
        op_b    = '0;
        op_ctrl = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (IDW'(k) == gnt_idx) begin
                op_a    = req_a_i[k*WIDTH +: WIDTH];
                op_b    = req_b_i[k*WIDTH +: WIDTH];
                op_ctrl = req_ctrl_i[k*4 +: 4];
            end
        end
    end

    always_comb begin
        alu_sum = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_of  = 1'b0;
        case (op_ctrl)
            AluAdd: begin
                alu_sum = {1'b0, op_a} + {1'b0, op_b};
                alu_res = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
                alu_of  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            AluSub: begin
                // Carry is the no-borrow bit of a + ~b + 1.
                alu_sum = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = alu_sum[WIDTH-1:0];
                alu_c   = alu_sum[WIDTH];
                alu_of  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            AluAnd:  alu_res = op_a & op_b;
            AluOr:   alu_res = op_a | op_b;
            AluXor:  alu_res = op_a ^ op_b;
            AluSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            AluSltu: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
            AluSll:  alu_res = op_a << op_b[ShW-1:0];
            AluSrl:  alu_res = op_a >> op_b[ShW-1:0];
            AluSra:  alu_res = $signed(op_a) >>> op_b[ShW-1:0];
            default: alu_res = '0;
        endcase
    end

    assign alu_flags = {alu_res == '0, alu_c, alu_res[WIDTH-1], alu_of};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else if (xfer) begin
            ptr_q        <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= gnt_idx;
            rsp_result_q <= alu_res;
            rsp_flags_q  <= alu_flags;
        end else if (rsp_ready_i) begin
            rsp_valid_q  <= 1'b0;
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_flags_o  = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gnt_cnt_q [NREQ];

    // Clear beats a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || stats_clr_i) begin
            for (int k = 0; k < int'(NREQ); k++) gnt_cnt_q[k] <= '0;
        end else if (xfer) begin
            gnt_cnt_q[gnt_idx] <= gnt_cnt_q[gnt_idx] + 16'd1;
        end
    end

    always_comb begin
        gnt_cnt_o = '0;
        for (int k = 0; k < int'(NREQ); k++) gnt_cnt_o[k*16 +: 16] = gnt_cnt_q[k];
    end
`endif

endmodule
